vproc_div_lane: RTL and testbench
=================================

# vproc_div_lane

Iterative single-element integer divider lane for the vector divide unit (UNIT_DIV). It consumes one decoded element operation per handshake: an `opcode_div` selector, `cfg_vsew` element width, and dividend/divisor. It produces the quotient or remainder with RISC-V V semantics through a valid/ready result port. The enclosing divide unit instantiates one or more lanes between operand unpacking and result packing.

## Interface
- `TAG_W`, default 8: width of the opaque tag carried from request to result (element index, mask bit, etc.).
- `clk_i` in 1: clock.
- `async_rst_ni` in 1: asynchronous active-low reset.
- `kill_i` in 1: abort any in-flight operation.
- `in_valid_i` in 1: request valid.
- `in_ready_o` out 1: lane can accept a request.
- `in_op_i` in 2 (`opcode_div`): DIV_VDIVU / DIV_VDIV / DIV_VREMU / DIV_VREM.
- `in_vsew_i` in 2 (`cfg_vsew`): element width.
- `in_dividend_i` in 32: dividend (vs2 element), valid in low SEW bits.
- `in_divisor_i` in 32: divisor (vs1 element or scalar), valid in low SEW bits.
- `in_tag_i` in TAG_W: request tag.
- `res_valid_o` out 1: result valid.
- `res_ready_i` in 1: consumer accepts result.
- `res_o` out 32: result; low SEW bits significant, upper bits zero.
- `res_tag_o` out TAG_W: tag of the result.

## Operation
- FSM states:
  - IDLE: `in_ready_o`=1.
  - CALC: iterative, one quotient bit per cycle.
  - DONE: `res_valid_o`=1.
- Width W = 8/16/32 for VSEW_8/16/32. VSEW_INVALID is treated as 32.
- Operand bits above W are ignored.
- Signedness: DIV_VDIV and DIV_VREM are signed; the others are unsigned.
- IDLE, on accept (`in_valid_i && in_ready_o`): latch op, W, tag, operand magnitudes (two's-complement negate if signed and negative), quotient sign (sign(a) XOR sign(b)) and remainder sign (sign(a)). Then:
  - divisor == 0: go to DONE. DIVU/DIV result = all ones in W bits. REMU/REM result = dividend (W bits).
  - signed, dividend == -2^(W-1) and divisor == -1: go to DONE. DIV result = dividend. REM result = 0.
  - otherwise: go to CALC, iteration counter = W-1, partial remainder = 0.
- CALC, each cycle (restoring division):
  - Shift the partial remainder left, bringing in the next dividend MSB.
  - Subtract the divisor magnitude if no borrow, and shift the resulting quotient bit in.
  - At counter == 0: apply sign correction (negate quotient if quotient sign is set; negate remainder if remainder sign is set), select quotient or remainder per op, and go to DONE.
- DONE: hold `res_o` and `res_tag_o` stable until `res_valid_o && res_ready_i`, then go to IDLE.
- `res_o` bits [31:W] are always 0.
- `kill_i`: from any state, go to IDLE on the next edge and drop the result. `kill_i` has priority over accept and over result handshake in the same cycle. A request presented while `kill_i` is high is not accepted.
- Reset: state IDLE; `in_ready_o`=1; `res_valid_o`=0; `res_o`=0; `res_tag_o`=0; internal registers zero. Reset mid-CALC or mid-DONE discards the operation.

## Timing
- Accept in cycle T:
  - normal case: `res_valid_o` rises at T+W+1 (after W CALC cycles).
  - special cases: `res_valid_o` rises at T+1.
- `in_ready_o` is high only in IDLE. It is a registered state decode, with no combinational path from `in_valid_i`.
- Throughput: one element per W+2 cycles when `res_ready_i` is held high (DONE → IDLE costs one cycle).
- Outputs are registered. `res_valid_o` does not depend combinationally on `res_ready_i`.
- Backpressure: DONE is held indefinitely. No new request is accepted while in DONE.

## Test plan
- Basic unsigned: VSEW_32, DIVU, 100 / 7 with tag 0x3A. Required: `res_o`=14 and `res_tag_o`=0x3A at T+33. REMU with the same operands gives 2.
- Signed narrow: VSEW_16, DIV, 0xFFF9 (-7) / 0x0002. Required: `res_o`=0x0000FFFD. REM gives 0x0000FFFF. Upper operand bits set to 0xABCD must not change either result.
- Divide by zero: VSEW_8, DIV, 0x15 / 0x00 gives 0x000000FF at T+1. REMU, VSEW_32, 5 / 0 gives 5 at T+1.
- Overflow: VSEW_8, DIV, 0x80 / 0xFF gives 0x00000080 at T+1. VSEW_8, REM with the same operands gives 0.
- Backpressure and throughput:
  - With `res_ready_i` low for 5 cycles in DONE: `res_o` stays stable and `in_ready_o`=0.
  - After the handshake: IDLE next cycle.
  - Back-to-back VSEW_8 requests with `res_ready_i`=1: one accept every 10 cycles.
- Kill and reset:
  - `kill_i` pulsed at T+4 of a VSEW_32 op: no `res_valid_o` ever appears, `in_ready_o`=1 at T+5, and the next op's result is correct.
  - `async_rst_ni` asserted mid-CALC: all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/vproc_div_lane_if.sv
// Request/result bundle between the divide unit and one divider lane.
// Signal names keep their lane-side direction suffix so both ends read the same.
interface vproc_div_lane_if #(
  parameter int unsigned TAG_W = 8
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [1:0]       in_op_i;
  logic [1:0]       in_vsew_i;
  logic [31:0]      in_dividend_i;
  logic [31:0]      in_divisor_i;
  logic [TAG_W-1:0] in_tag_i;
  logic             res_valid_o;
  logic             res_ready_i;
  logic [31:0]      res_o;
  logic [TAG_W-1:0] res_tag_o;

  modport master (
    output in_valid_i, in_op_i, in_vsew_i, in_dividend_i, in_divisor_i, in_tag_i, res_ready_i,
    input  in_ready_o, res_valid_o, res_o, res_tag_o
  );

  modport slave (
    input  in_valid_i, in_op_i, in_vsew_i, in_dividend_i, in_divisor_i, in_tag_i, res_ready_i,
    output in_ready_o, res_valid_o, res_o, res_tag_o
  );
endinterface

// File: rtl/vproc_div_lane.sv
// Iterative restoring divider lane: one quotient bit per cycle, RISC-V V
// semantics for divide-by-zero and signed overflow, valid/ready result port.
//
// state  | meaning
// IDLE   | waiting for a request, in_ready_o high
// CALC   | one restoring-division step per cycle
// DONE   | result held on res_o until the consumer takes it
module vproc_div_lane #(
  parameter int unsigned TAG_W = 8
) (
  input  logic                  clk_i,
  input  logic                  async_rst_ni,
  input  logic                  kill_i,
  vproc_div_lane_if.slave       bus
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [31:0]      mask_q, mask_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [31:0]      rem_q, rem_d;
  logic [31:0]      quo_q, quo_d;
  logic [31:0]      res_q, res_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic [31:0] in_mask, in_msb, a_w, b_w, a_mag, b_mag;
  logic [4:0]  in_cnt;
  logic        is_signed, sa, sb, div_zero, ovf;
  logic [32:0] trial;
  logic        ge;
  logic [31:0] diff, rem_n, quo_n, q_fix, r_fix;

  // Request decode: mask to SEW, then take magnitudes for the signed ops
  always_comb begin
    in_mask = 32'hFFFF_FFFF;
    in_cnt  = 5'd31;
    case (bus.in_vsew_i)
      2'd0: begin in_mask = 32'h0000_00FF; in_cnt = 5'd7;  end
      2'd1: begin in_mask = 32'h0000_FFFF; in_cnt = 5'd15; end
      default: begin in_mask = 32'hFFFF_FFFF; in_cnt = 5'd31; end
    endcase
    in_msb    = in_mask ^ (in_mask >> 1);
    a_w       = bus.in_dividend_i & in_mask;
    b_w       = bus.in_divisor_i & in_mask;
    is_signed = bus.in_op_i[0];
    sa        = is_signed & (|(a_w & in_msb));
    sb        = is_signed & (|(b_w & in_msb));
    a_mag     = sa ? ((-a_w) & in_mask) : a_w;
    b_mag     = sb ? ((-b_w) & in_mask) : b_w;
    div_zero  = (b_w == 32'd0);
    ovf       = is_signed && (a_w == in_msb) && (b_w == in_mask);
  end

  // One restoring step; the remainder always stays below the divisor, so 32 bits suffice
  always_comb begin
    trial = {rem_q, a_q[cnt_q]};
    ge    = (trial >= {1'b0, b_q});
    diff  = trial[31:0] - b_q;
    rem_n = ge ? diff : trial[31:0];
    quo_n = (quo_q << 1) | {31'd0, ge};
    q_fix = (qneg_q ? -quo_n : quo_n) & mask_q;
    r_fix = (rneg_q ? -rem_n : rem_n) & mask_q;
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    mask_d  = mask_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    tag_d   = tag_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid_i && !kill_i) begin
          op_d   = bus.in_op_i;
          mask_d = in_mask;
          tag_d  = bus.in_tag_i;
          a_d    = a_mag;
          b_d    = b_mag;
          qneg_d = sa ^ sb;
          rneg_d = sa;
          rem_d  = 32'd0;
          quo_d  = 32'd0;
          cnt_d  = in_cnt;
          if (div_zero) begin
            res_d   = bus.in_op_i[1] ? a_w : in_mask;
            state_d = S_DONE;
          end else if (ovf) begin
            res_d   = bus.in_op_i[1] ? 32'd0 : a_w;
            state_d = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        rem_d = rem_n;
        quo_d = quo_n;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) begin
          res_d   = op_q[1] ? r_fix : q_fix;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.res_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (kill_i) state_d = S_IDLE;
  end

  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      state_q <= S_IDLE;
      op_q    <= 2'd0;
      mask_q  <= 32'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      res_q   <= 32'd0;
      cnt_q   <= 5'd0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      mask_q  <= mask_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      tag_q   <= tag_d;
    end
  end

  assign bus.in_ready_o  = (state_q == S_IDLE);
  assign bus.res_valid_o = (state_q == S_DONE);
  assign bus.res_o       = res_q;
  assign bus.res_tag_o   = tag_q;

endmodule

// File: tb/tb_vproc_div_lane.sv
// Directed bench for vproc_div_lane: hand-computed quotients/remainders,
// latency, backpressure, throughput, kill and asynchronous reset.
module tb_vproc_div_lane;

  localparam logic [1:0] OP_DIVU = 2'd0, OP_DIV = 2'd1, OP_REMU = 2'd2, OP_REM = 2'd3;
  localparam logic [1:0] SEW8 = 2'd0, SEW16 = 2'd1, SEW32 = 2'd2, SEWINV = 2'd3;

  logic clk_i = 1'b0;
  logic async_rst_ni = 1'b0;
  logic kill_i = 1'b0;
  int   checks = 0;
  int   errors = 0;

  vproc_div_lane_if #(.TAG_W(8)) bus ();

  vproc_div_lane #(.TAG_W(8)) dut (
    .clk_i        (clk_i),
    .async_rst_ni (async_rst_ni),
    .kill_i       (kill_i),
    .bus          (bus)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, got, exp);
    end
  endtask

  // Issue one request with res_ready_i high; check latency, result and tag.
  task automatic do_op(input string name, input logic [1:0] op, input logic [1:0] vsew,
                       input logic [31:0] a, input logic [31:0] b, input logic [7:0] tag,
                       input logic [31:0] exp, input int lat);
    chk({name, "_ready"}, {31'd0, bus.in_ready_o}, 32'd1);
    bus.in_op_i       = op;
    bus.in_vsew_i     = vsew;
    bus.in_dividend_i = a;
    bus.in_divisor_i  = b;
    bus.in_tag_i      = tag;
    bus.in_valid_i    = 1'b1;
    bus.res_ready_i   = 1'b1;
    tick();
    bus.in_valid_i = 1'b0;
    for (int i = 1; i < lat; i++) begin
      chk({name, "_early"}, {31'd0, bus.res_valid_o}, 32'd0);
      tick();
    end
    chk({name, "_valid"}, {31'd0, bus.res_valid_o}, 32'd1);
    chk({name, "_res"}, bus.res_o, exp);
    chk({name, "_tag"}, {24'd0, bus.res_tag_o}, {24'd0, tag});
    tick();
    chk({name, "_idle"}, {31'd0, bus.in_ready_o}, 32'd1);
  endtask

  initial begin
    int  n;
    logic seen;
    bus.in_valid_i    = 1'b0;
    bus.in_op_i       = 2'd0;
    bus.in_vsew_i     = 2'd0;
    bus.in_dividend_i = 32'd0;
    bus.in_divisor_i  = 32'd0;
    bus.in_tag_i      = 8'd0;
    bus.res_ready_i   = 1'b1;

    #2;
    chk("rst_ready", {31'd0, bus.in_ready_o}, 32'd1);
    chk("rst_valid", {31'd0, bus.res_valid_o}, 32'd0);
    chk("rst_res", bus.res_o, 32'd0);
    chk("rst_tag", {24'd0, bus.res_tag_o}, 32'd0);
    #10 async_rst_ni = 1'b1;
    tick();

    // Basic unsigned, VSEW_32
    do_op("divu32", OP_DIVU, SEW32, 32'd100, 32'd7, 8'h3A, 32'd14, 33);
    do_op("remu32", OP_REMU, SEW32, 32'd100, 32'd7, 8'h3B, 32'd2, 33);

    // Signed narrow, with and without garbage above SEW
    do_op("div16", OP_DIV, SEW16, 32'h0000_FFF9, 32'h0000_0002, 8'h10, 32'h0000_FFFD, 17);
    do_op("rem16", OP_REM, SEW16, 32'h0000_FFF9, 32'h0000_0002, 8'h11, 32'h0000_FFFF, 17);
    do_op("div16_hi", OP_DIV, SEW16, 32'hABCD_FFF9, 32'hABCD_0002, 8'h12, 32'h0000_FFFD, 17);
    do_op("rem16_hi", OP_REM, SEW16, 32'hABCD_FFF9, 32'hABCD_0002, 8'h13, 32'h0000_FFFF, 17);

    // Negative divisor, and invalid VSEW behaving as 32-bit
    do_op("div8_nb", OP_DIV, SEW8, 32'h07, 32'hFE, 8'h20, 32'h0000_00FD, 9);
    do_op("rem8_nb", OP_REM, SEW8, 32'h07, 32'hFE, 8'h21, 32'h0000_0001, 9);
    do_op("div_inv", OP_DIV, SEWINV, 32'hFFFF_FF9C, 32'd7, 8'h22, 32'hFFFF_FFF2, 33);

    // Divide by zero and signed overflow finish in one cycle
    do_op("dz_div8", OP_DIV, SEW8, 32'h15, 32'h00, 8'h30, 32'h0000_00FF, 1);
    do_op("dz_remu32", OP_REMU, SEW32, 32'd5, 32'd0, 8'h31, 32'd5, 1);
    do_op("ovf_div8", OP_DIV, SEW8, 32'h80, 32'hFF, 8'h32, 32'h0000_0080, 1);
    do_op("ovf_rem8", OP_REM, SEW8, 32'h80, 32'hFF, 8'h33, 32'd0, 1);

    // Backpressure: result held 5 cycles, no new accept
    bus.res_ready_i   = 1'b0;
    bus.in_op_i       = OP_DIVU;
    bus.in_vsew_i     = SEW8;
    bus.in_dividend_i = 32'd200;
    bus.in_divisor_i  = 32'd9;
    bus.in_tag_i      = 8'h55;
    bus.in_valid_i    = 1'b1;
    tick();
    bus.in_valid_i = 1'b0;
    repeat (8) tick();
    chk("bp_valid", {31'd0, bus.res_valid_o}, 32'd1);
    chk("bp_res", bus.res_o, 32'd22);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_res", bus.res_o, 32'd22);
      chk("bp_hold_tag", {24'd0, bus.res_tag_o}, 32'h55);
      chk("bp_hold_ready", {31'd0, bus.in_ready_o}, 32'd0);
    end
    bus.res_ready_i = 1'b1;
    tick();
    chk("bp_idle_ready", {31'd0, bus.in_ready_o}, 32'd1);
    chk("bp_idle_valid", {31'd0, bus.res_valid_o}, 32'd0);

    // Back-to-back VSEW_8: accepts 10 cycles apart
    bus.in_op_i       = OP_DIVU;
    bus.in_vsew_i     = SEW8;
    bus.in_dividend_i = 32'd100;
    bus.in_divisor_i  = 32'd7;
    bus.in_tag_i      = 8'h01;
    bus.in_valid_i    = 1'b1;
    tick();
    n = 1;
    seen = 1'b0;
    while (!bus.in_ready_o && n < 40) begin
      if (bus.res_valid_o) begin
        seen = 1'b1;
        chk("b2b_res0", bus.res_o, 32'd14);
      end
      tick();
      n++;
    end
    chk("b2b_seen", {31'd0, seen}, 32'd1);
    chk("b2b_period", n, 32'd10);
    do_op("b2b_op1", OP_DIVU, SEW8, 32'd250, 32'd3, 8'h02, 32'd83, 9);

    // Kill during CALC
    bus.in_op_i       = OP_DIVU;
    bus.in_vsew_i     = SEW32;
    bus.in_dividend_i = 32'd1000;
    bus.in_divisor_i  = 32'd3;
    bus.in_tag_i      = 8'h40;
    bus.in_valid_i    = 1'b1;
    tick();
    bus.in_valid_i = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      if (bus.res_valid_o) seen = 1'b1;
      tick();
    end
    kill_i = 1'b1;
    tick();
    kill_i = 1'b0;
    chk("kill_ready", {31'd0, bus.in_ready_o}, 32'd1);
    for (int i = 0; i < 40; i++) begin
      if (bus.res_valid_o) seen = 1'b1;
      tick();
    end
    chk("kill_no_valid", {31'd0, seen}, 32'd0);
    do_op("after_kill", OP_DIVU, SEW32, 32'd1000, 32'd3, 8'h41, 32'd333, 33);

    // Asynchronous reset mid-CALC
    bus.in_op_i       = OP_DIVU;
    bus.in_vsew_i     = SEW32;
    bus.in_dividend_i = 32'd77;
    bus.in_divisor_i  = 32'd5;
    bus.in_tag_i      = 8'h66;
    bus.in_valid_i    = 1'b1;
    tick();
    bus.in_valid_i = 1'b0;
    repeat (3) tick();
    chk("pre_rst_ready", {31'd0, bus.in_ready_o}, 32'd0);
    #2 async_rst_ni = 1'b0;
    #1;
    chk("arst_ready", {31'd0, bus.in_ready_o}, 32'd1);
    chk("arst_valid", {31'd0, bus.res_valid_o}, 32'd0);
    chk("arst_res", bus.res_o, 32'd0);
    chk("arst_tag", {24'd0, bus.res_tag_o}, 32'd0);
    #2 async_rst_ni = 1'b1;
    tick();
    do_op("after_rst", OP_REMU, SEW16, 32'd1000, 32'd7, 8'h77, 32'd6, 17);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
